// File: rtl/axis_master.sv
// axis_master: AXI4-Stream source of fixed-length packets carrying incrementing beat indices
module axis_master #(
  parameter int DATA_WIDTH  = 8,
  parameter int PACKET_SIZE = 256,
  parameter int IDLE_CYCLES = 0,
  parameter int NUM_PACKETS = 0
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic [DATA_WIDTH-1:0] m_tdata,
  output logic                  m_tvalid,
  input  logic                  m_tready,
  output logic                  m_tlast
);
  localparam int CW = PACKET_SIZE > 1 ? $clog2(PACKET_SIZE) : 1;
  localparam int PW = NUM_PACKETS > 0 ? $clog2(NUM_PACKETS + 1) : 1;
  localparam int GW = IDLE_CYCLES > 0 ? $clog2(IDLE_CYCLES + 1) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(PACKET_SIZE - 1);
  localparam logic [1:0] RESET_IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2, DONE = 2'd3;
  logic [1:0] state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [PW-1:0] pkt_q, pkt_d, pkt_inc;
  logic [GW-1:0] gap_q, gap_d;
  logic [DATA_WIDTH-1:0] tdata_q, tdata_d;
  logic tvalid_q, tvalid_d, tlast_q, tlast_d, acc, is_last;
  // Next state; outputs are precomputed from the next state so they leave as flops
  always_comb begin
    acc = tvalid_q & m_tready;
    is_last = cnt_q == LAST_IDX;
    pkt_inc = pkt_q + PW'(1);
    state_d = state_q;
    cnt_d = cnt_q;
    pkt_d = pkt_q;
    gap_d = gap_q;
    case (state_q)
      RESET_IDLE: state_d = SEND;
      SEND: if (acc) begin
        cnt_d = is_last ? '0 : cnt_q + CW'(1);
        if (is_last) begin
          pkt_d = NUM_PACKETS != 0 ? pkt_inc : pkt_q;
          gap_d = '0;
          state_d = (NUM_PACKETS != 0 && pkt_inc == PW'(NUM_PACKETS)) ? DONE :
                    IDLE_CYCLES > 0 ? GAP : SEND;
        end
      end
      GAP: begin
        gap_d = gap_q + GW'(1);
        if (gap_q == GW'(IDLE_CYCLES - 1)) state_d = SEND;
      end
      default: ;
    endcase
    tvalid_d = state_d == SEND;
    tlast_d = tvalid_d && cnt_d == LAST_IDX;
    tdata_d = DATA_WIDTH'(cnt_d);
  end
  // State and registered outputs; reset aborts any packet immediately
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= RESET_IDLE;
      cnt_q <= '0;
      pkt_q <= '0;
      gap_q <= '0;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      tdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      pkt_q <= pkt_d;
      gap_q <= gap_d;
      tvalid_q <= tvalid_d;
      tlast_q <= tlast_d;
      tdata_q <= tdata_d;
    end
  end
  assign m_tvalid = tvalid_q;
  assign m_tlast = tlast_q;
  assign m_tdata = tdata_q;
endmodule

// File: tb/tb_axis_master.sv
// tb_axis_master: directed checks of free flow, back-pressure, gap/stop, width wrap and reset
module tb_axis_master;
  logic clk = 1'b0, reset_n = 1'b0, bp_rdy = 1'b0, acc1 = 1'b0;
  logic [7:0] d0, d1, d2, d4;
  logic [1:0] d3;
  logic v0, v1, v2, v3, v4, l0, l1, l2, l3, l4;
  int checks = 0, errors = 0;
  int e1 = 0, n1 = 0;
  always #5 clk = ~clk;
  axis_master #(.DATA_WIDTH(8), .PACKET_SIZE(8)) u0 (
    .clk(clk), .reset_n(reset_n), .m_tdata(d0), .m_tvalid(v0), .m_tready(1'b1), .m_tlast(l0));
  axis_master #(.DATA_WIDTH(8), .PACKET_SIZE(8)) u1 (
    .clk(clk), .reset_n(reset_n), .m_tdata(d1), .m_tvalid(v1), .m_tready(bp_rdy), .m_tlast(l1));
  axis_master #(.DATA_WIDTH(8), .PACKET_SIZE(8), .IDLE_CYCLES(3), .NUM_PACKETS(2)) u2 (
    .clk(clk), .reset_n(reset_n), .m_tdata(d2), .m_tvalid(v2), .m_tready(1'b1), .m_tlast(l2));
  axis_master #(.DATA_WIDTH(2), .PACKET_SIZE(6)) u3 (
    .clk(clk), .reset_n(reset_n), .m_tdata(d3), .m_tvalid(v3), .m_tready(1'b1), .m_tlast(l3));
  axis_master #(.DATA_WIDTH(8), .PACKET_SIZE(1)) u4 (
    .clk(clk), .reset_n(reset_n), .m_tdata(d4), .m_tvalid(v4), .m_tready(1'b1), .m_tlast(l4));
  // Ready pattern 15 ns high / 20 ns low, offset so edges never coincide with a clock edge
  initial begin
    #2;
    forever begin
      bp_rdy = 1'b1;
      #15;
      bp_rdy = 1'b0;
      #20;
    end
  end
  // Records whether u1 transferred a beat on each rising edge
  always @(posedge clk) acc1 <= v1 & bp_rdy;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, got, exp);
    end
  endtask
  initial begin
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_valid", {31'd0, v0}, 0);
      chk("rst_last", {31'd0, l0}, 0);
      chk("rst_data", {24'd0, d0}, 0);
    end
    reset_n = 1'b1;
    for (int c = 0; c < 40; c++) begin
      @(negedge clk);
      chk("free_valid", {31'd0, v0}, 1);
      chk("free_data", {24'd0, d0}, c % 8);
      chk("free_last", {31'd0, l0}, (c % 8) == 7);
      if (acc1) begin
        e1 = (e1 + 1) % 8;
        n1++;
      end
      chk("bp_valid", {31'd0, v1}, 1);
      chk("bp_data", {24'd0, d1}, e1);
      chk("bp_last", {31'd0, l1}, e1 == 7);
      chk("gap_valid", {31'd0, v2}, (c < 8) || (c >= 11 && c < 19));
      if (c < 8 || (c >= 11 && c < 19)) begin
        chk("gap_data", {24'd0, d2}, c < 8 ? c : c - 11);
        chk("gap_last", {31'd0, l2}, c == 7 || c == 18);
      end
      chk("wrap_valid", {31'd0, v3}, 1);
      chk("wrap_data", {30'd0, d3}, (c % 6) % 4);
      chk("wrap_last", {31'd0, l3}, (c % 6) == 5);
      chk("one_beat", {23'd0, v4, l4, d4[6:0]}, 32'h180);
    end
    chk("bp_progress", {31'd0, n1 >= 10}, 1);
    for (int i = 0; i < 16 && d0 !== 8'd4; i++) @(negedge clk);
    chk("wait_beat4", {24'd0, d0}, 4);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_valid", {31'd0, v0}, 0);
    chk("abort_data", {24'd0, d0}, 0);
    chk("abort_last", {31'd0, l0}, 0);
    chk("abort_u2_valid", {31'd0, v2}, 0);
    @(negedge clk);
    chk("held_valid", {31'd0, v0}, 0);
    reset_n = 1'b1;
    @(negedge clk);
    chk("restart_valid", {31'd0, v0}, 1);
    chk("restart_data", {24'd0, d0}, 0);
    chk("restart_u2", {23'd0, v2, d2}, 32'h100);
    @(negedge clk);
    chk("restart_next", {24'd0, d0}, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
